// File: rtl/hasher_pkg.sv
// Shared types for the hash readout path: the hash word type, its byte count
// and the readout state encoding. The FILL state only exists when
// HASH_READOUT_UNDERFLOW_EN is defined.
package hasher_pkg;

    typedef logic [31:0] hash_t;

    localparam int HASH_BYTES = 4;

    localparam logic [1:0] LAST_BYTE_IDX = 2'(HASH_BYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1
`ifdef HASH_READOUT_UNDERFLOW_EN
        ,
        ST_FILL = 2'd2
`endif
    } readout_state_t;

endpackage

// File: rtl/hash_readout.sv
// hash_readout: pops 32-bit FNV-1a results from a first-word-fall-through FIFO
// and streams each one as four bytes to the I2C target transmit path.
// The next hash is popped on the final-byte handshake, so back-to-back hashes
// are sent without a bubble.
// Optional feature: define HASH_READOUT_UNDERFLOW_EN to answer a read on an
// empty FIFO with a single IDLE_BYTE (tx_last=1) and set the sticky
// underflow flag. Without it, tx_ready is ignored while idle and underflow
// is tied low.
module hash_readout
    import hasher_pkg::*;
#(
    parameter bit         MSB_FIRST = 1'b1,
    parameter logic [7:0] IDLE_BYTE = 8'hFF
) (
    input  logic       clk,
    input  logic       reset,
    input  hash_t      res_data,
    input  logic       res_empty,
    output logic       res_pop,
    input  logic       tx_ready,
    output logic       tx_valid,
    output logic [7:0] tx_byte,
    output logic       tx_last,
    output logic       underflow
);

    readout_state_t state;
    readout_state_t state_next;

    logic [1:0] idx;
    logic [1:0] idx_next;
    logic [1:0] idx_plus;
    hash_t      hold;
    hash_t      hold_next;
    logic       valid_next;
    logic [7:0] byte_next;
    logic       last_next;
    logic       handshake;

    hash_t      mux_word;
    logic [1:0] mux_idx;
    logic [7:0] byte_sel;

`ifdef HASH_READOUT_UNDERFLOW_EN
    logic       underflow_next;
`endif

    assign handshake = tx_valid && tx_ready;
    assign idx_plus  = idx + 2'd1;

    // Pop strobe: take a new hash when idle, or on the final-byte handshake so the next hash follows without a gap.
    always_comb begin
        res_pop = 1'b0;
        if (!reset) begin
            unique case (state)
                ST_IDLE: res_pop = !res_empty;
                ST_SEND: res_pop = handshake && (idx == LAST_BYTE_IDX) && !res_empty;
                default: res_pop = 1'b0;
            endcase
        end
    end

    // Byte mux: a freshly popped word starts at byte 0, otherwise the held word advances to its next byte.
    always_comb begin
        byte_sel = 8'h00;
        mux_word = res_pop ? res_data : hold;
        mux_idx  = res_pop ? 2'd0 : idx_plus;
        if (MSB_FIRST) begin
            unique case (mux_idx)
                2'd0: byte_sel = mux_word[31:24];
                2'd1: byte_sel = mux_word[23:16];
                2'd2: byte_sel = mux_word[15:8];
                2'd3: byte_sel = mux_word[7:0];
                default: byte_sel = 8'h00;
            endcase
        end else begin
            unique case (mux_idx)
                2'd0: byte_sel = mux_word[7:0];
                2'd1: byte_sel = mux_word[15:8];
                2'd2: byte_sel = mux_word[23:16];
                2'd3: byte_sel = mux_word[31:24];
                default: byte_sel = 8'h00;
            endcase
        end
    end

    // Next-state logic: every output register is loaded here so the byte, valid and last flags change together.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        hold_next  = hold;
        valid_next = tx_valid;
        byte_next  = tx_byte;
        last_next  = tx_last;
`ifdef HASH_READOUT_UNDERFLOW_EN
        underflow_next = underflow;
`endif
        unique case (state)
            ST_IDLE: begin
                if (!res_empty) begin
                    state_next = ST_SEND;
                    hold_next  = res_data;
                    idx_next   = 2'd0;
                    valid_next = 1'b1;
                    byte_next  = byte_sel;
                    last_next  = 1'b0;
                end
`ifdef HASH_READOUT_UNDERFLOW_EN
                else if (tx_ready) begin
                    state_next     = ST_FILL;
                    valid_next     = 1'b1;
                    byte_next      = IDLE_BYTE;
                    last_next      = 1'b1;
                    underflow_next = 1'b1;
                end
`endif
            end
            ST_SEND: begin
                if (handshake) begin
                    if (idx == LAST_BYTE_IDX) begin
                        if (!res_empty) begin
                            hold_next = res_data;
                            idx_next  = 2'd0;
                            byte_next = byte_sel;
                            last_next = 1'b0;
                        end else begin
                            state_next = ST_IDLE;
                            idx_next   = 2'd0;
                            valid_next = 1'b0;
                            byte_next  = IDLE_BYTE;
                            last_next  = 1'b0;
                        end
                    end else begin
                        idx_next  = idx_plus;
                        byte_next = byte_sel;
                        last_next = (idx_plus == LAST_BYTE_IDX);
                    end
                end
            end
`ifdef HASH_READOUT_UNDERFLOW_EN
            ST_FILL: begin
                if (handshake) begin
                    state_next = ST_IDLE;
                    valid_next = 1'b0;
                    last_next  = 1'b0;
                end
            end
`endif
            default: begin
                state_next = ST_IDLE;
                idx_next   = 2'd0;
                valid_next = 1'b0;
                last_next  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops any partially sent hash.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            idx      <= 2'd0;
            hold     <= '0;
            tx_valid <= 1'b0;
            tx_byte  <= 8'h00;
            tx_last  <= 1'b0;
        end else begin
            state    <= state_next;
            idx      <= idx_next;
            hold     <= hold_next;
            tx_valid <= valid_next;
            tx_byte  <= byte_next;
            tx_last  <= last_next;
        end
    end

`ifdef HASH_READOUT_UNDERFLOW_EN
    // Sticky underflow flag, only cleared by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            underflow <= 1'b0;
        end else begin
            underflow <= underflow_next;
        end
    end
`else
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_hash_readout.sv
// tb_hash_readout: drives two hash_readout instances (MSB-first and LSB-first)
// from one FIFO model and checks both byte streams against a reference that
// expands each popped hash into its expected bytes.
// With HASH_READOUT_UNDERFLOW_EN defined, the empty-FIFO filler byte is also
// exercised.
module tb_hash_readout;
    import hasher_pkg::*;

    logic       clk;
    logic       reset;
    hash_t      res_data;
    logic       res_empty;
    logic       tx_ready;

    logic       pop_m, valid_m, last_m, uf_m;
    logic [7:0] byte_m;
    logic       pop_l, valid_l, last_l, uf_l;
    logic [7:0] byte_l;

    typedef struct {
        logic [7:0] msb_byte;
        logic [7:0] lsb_byte;
        logic       last;
    } exp_byte_t;

    hash_t      fifo_q[$];
    exp_byte_t  exp_q[$];
    logic [7:0] cap_m[$];
    logic [7:0] cap_l[$];

    int checks_total  = 0;
    int checks_passed = 0;
    int pops_seen     = 0;
    int valid_run     = 0;
    int max_valid_run = 0;

    hash_readout #(.MSB_FIRST(1'b1), .IDLE_BYTE(8'hFF)) dut_msb (
        .clk(clk), .reset(reset), .res_data(res_data), .res_empty(res_empty),
        .res_pop(pop_m), .tx_ready(tx_ready), .tx_valid(valid_m),
        .tx_byte(byte_m), .tx_last(last_m), .underflow(uf_m)
    );

    hash_readout #(.MSB_FIRST(1'b0), .IDLE_BYTE(8'hFF)) dut_lsb (
        .clk(clk), .reset(reset), .res_data(res_data), .res_empty(res_empty),
        .res_pop(pop_l), .tx_ready(tx_ready), .tx_valid(valid_l),
        .tx_byte(byte_l), .tx_last(last_l), .underflow(uf_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks_total++;
        if (actual === expected) checks_passed++;
        else $display("[TB] FAIL %s: observed %h, expected %h", tag, actual, expected);
    endtask

    task automatic driveFifo();
        res_empty = (fifo_q.size() == 0);
        res_data  = res_empty ? '0 : fifo_q[0];
    endtask

    task automatic pushHash(input hash_t w);
        fifo_q.push_back(w);
        driveFifo();
    endtask

    // One clock cycle: sample at the falling edge, compare, advance the model, then drive the next inputs.
    task automatic tickCycle(input logic ready_next);
        logic      want_pop;
        logic      handshake;
        hash_t     w;
        exp_byte_t e;
        @(negedge clk);
        want_pop  = (fifo_q.size() != 0) &&
                    ((exp_q.size() == 0) || (exp_q.size() == 1 && tx_ready));
        handshake = (exp_q.size() != 0) && tx_ready;
        checkOutput("valid_msb", valid_m, exp_q.size() != 0);
        checkOutput("valid_lsb", valid_l, exp_q.size() != 0);
        checkOutput("pop_msb", pop_m, want_pop);
        checkOutput("pop_lsb", pop_l, want_pop);
        checkOutput("underflow_msb", uf_m, 0);
        if (exp_q.size() != 0) begin
            checkOutput("byte_msb", byte_m, exp_q[0].msb_byte);
            checkOutput("byte_lsb", byte_l, exp_q[0].lsb_byte);
            checkOutput("last_msb", last_m, exp_q[0].last);
            checkOutput("last_lsb", last_l, exp_q[0].last);
        end
        if (pop_m) pops_seen++;
        if (valid_m) begin
            valid_run++;
            if (valid_run > max_valid_run) max_valid_run = valid_run;
        end else begin
            valid_run = 0;
        end
        if (handshake) begin
            cap_m.push_back(byte_m);
            cap_l.push_back(byte_l);
            e = exp_q.pop_front();
        end
        if (want_pop) begin
            w = fifo_q.pop_front();
            for (int i = 0; i < HASH_BYTES; i++) begin
                e.msb_byte = 8'(w >> (8 * (HASH_BYTES - 1 - i)));
                e.lsb_byte = 8'(w >> (8 * i));
                e.last     = (i == HASH_BYTES - 1);
                exp_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        tx_ready = ready_next;
`ifdef HASH_READOUT_UNDERFLOW_EN
        if (fifo_q.size() == 0 && exp_q.size() == 0) tx_ready = 1'b0;
`endif
        driveFifo();
    endtask

    // Random traffic: hashes arrive at random times, the target stalls at random.
    task automatic applyStimulus(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            if (fifo_q.size() < 4 && $urandom_range(0, 4) == 0) pushHash($urandom);
            tickCycle($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic drainAll(input int bound);
        int n = 0;
        while ((fifo_q.size() != 0 || exp_q.size() != 0) && n < bound) begin
            tickCycle(1'b1);
            n++;
        end
        checkOutput("drain_left", fifo_q.size() + exp_q.size(), 0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_valid"}, {valid_m, valid_l}, 2'b00);
        checkOutput({tag, "_byte"}, {byte_m, byte_l}, 16'h0000);
        checkOutput({tag, "_last"}, {last_m, last_l}, 2'b00);
        checkOutput({tag, "_pop"}, {pop_m, pop_l}, 2'b00);
        checkOutput({tag, "_underflow"}, {uf_m, uf_l}, 2'b00);
    endtask

    // Called just after a rising edge; outputs must clear without waiting for a clock.
    task automatic pulseReset();
        reset = 1'b1;
        #1;
        checkResetOutputs("reset");
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        driveFifo();
    endtask

    task automatic checkSequence(input string tag, input logic [31:0] want_m, input logic [31:0] want_l);
        logic [31:0] got_m;
        logic [31:0] got_l;
        checkOutput({tag, "_count"}, cap_m.size(), 4);
        got_m = '0;
        got_l = '0;
        for (int i = 0; i < 4 && i < cap_m.size(); i++) begin
            got_m = {got_m[23:0], cap_m[i]};
            got_l = {got_l[23:0], cap_l[i]};
        end
        checkOutput({tag, "_msb_seq"}, got_m, want_m);
        checkOutput({tag, "_lsb_seq"}, got_l, want_l);
    endtask

    initial begin
        int start_pops;
        reset     = 1'b1;
        tx_ready  = 1'b0;
        res_empty = 1'b1;
        res_data  = '0;
        #1;
        checkResetOutputs("init");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single hash, both byte orders, exactly one pop.
        cap_m.delete(); cap_l.delete();
        start_pops = pops_seen;
        pushHash(32'h811C9DC5);
        tx_ready = 1'b1;
        repeat (7) tickCycle(1'b1);
        checkOutput("single_pops", pops_seen - start_pops, 1);
        checkSequence("single", 32'h811C9DC5, 32'hC59D1C81);

        // Two queued hashes stream as eight consecutive valid cycles.
        cap_m.delete(); cap_l.delete();
        start_pops    = pops_seen;
        max_valid_run = 0;
        valid_run     = 0;
        pushHash(32'hE40C292C);
        pushHash(32'h050C5D7E);
        repeat (11) tickCycle(1'b1);
        checkOutput("b2b_pops", pops_seen - start_pops, 2);
        checkOutput("b2b_valid_run", max_valid_run, 8);
        checkOutput("b2b_bytes", cap_m.size(), 8);

        // Target stalls 1,0,0,1 during the hash.
        cap_m.delete(); cap_l.delete();
        pushHash(32'h811C9DC5);
        tx_ready = 1'b1;
        tickCycle(1'b1);
        tickCycle(1'b0);
        tickCycle(1'b0);
        tickCycle(1'b1);
        repeat (6) tickCycle(1'b1);
        checkSequence("stall", 32'h811C9DC5, 32'hC59D1C81);

        // Reset after the second byte discards the rest; the next hash starts at byte 0.
        cap_m.delete(); cap_l.delete();
        start_pops = pops_seen;
        pushHash(32'h811C9DC5);
        tx_ready = 1'b1;
        repeat (3) tickCycle(1'b1);
        checkOutput("mid_bytes_before_reset", cap_m.size(), 2);
        pulseReset();
        repeat (2) tickCycle(1'b1);
        checkOutput("mid_no_repop", pops_seen - start_pops, 1);
        cap_m.delete(); cap_l.delete();
        pushHash(32'hE40C292C);
        tx_ready = 1'b1;
        repeat (7) tickCycle(1'b1);
        checkSequence("after_reset", 32'hE40C292C, 32'h2C290CE4);

        // Randomized traffic with random back-pressure.
        applyStimulus(1500);
        drainAll(200);
        tickCycle(1'b1);

`ifdef HASH_READOUT_UNDERFLOW_EN
        // Read on an empty FIFO yields one filler byte and a sticky underflow.
        tx_ready = 1'b1;
        @(negedge clk);
        checkOutput("fill_idle_pop", {pop_m, pop_l}, 2'b00);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("fill_valid", {valid_m, valid_l}, 2'b11);
        checkOutput("fill_byte", {byte_m, byte_l}, 16'hFFFF);
        checkOutput("fill_last", {last_m, last_l}, 2'b11);
        checkOutput("fill_underflow", {uf_m, uf_l}, 2'b11);
        checkOutput("fill_pop", {pop_m, pop_l}, 2'b00);
        @(posedge clk);
        #1;
        tx_ready = 1'b0;
        repeat (4) begin
            @(negedge clk);
            checkOutput("fill_after_valid", {valid_m, valid_l}, 2'b00);
            checkOutput("fill_sticky", {uf_m, uf_l}, 2'b11);
            checkOutput("fill_after_pop", {pop_m, pop_l}, 2'b00);
            @(posedge clk);
            #1;
        end
        pulseReset();
`endif

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/hash_readout.md
HASH_READOUT -- requirements
Module: hash_readout

Interface
REQ-001 SHALL have parameter MSB_FIRST, default 1, meaning byte 0 sent is hash[31:24] when 1 and hash[7:0] when 0.
REQ-002 SHALL have parameter IDLE_BYTE, default 8'hFF, meaning the filler byte sent on underflow.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port res_data, input, 32, the FNV-1a hash result at the head of the result FIFO (first-word-fall-through).
REQ-006 SHALL have port res_empty, input, 1, high when the result FIFO holds no hash.
REQ-007 SHALL have port res_pop, output, 1, one-cycle pop strobe to the result FIFO.
REQ-008 SHALL have port tx_ready, input, 1, high when the I2C target transmit path accepts a byte.
REQ-009 SHALL have port tx_valid, output, 1, high when tx_byte holds a valid byte.
REQ-010 SHALL have port tx_byte, output, 8, the byte offered to the I2C target.
REQ-011 SHALL have port tx_last, output, 1, high with the fourth byte of a hash.
REQ-012 SHALL have port underflow, output, 1, sticky flag set when a read hit an empty FIFO.

Function
REQ-013 SHALL implement states IDLE and SEND, plus FILL when the underflow feature is compiled in.
REQ-014 SHALL, in IDLE with res_empty low, assert res_pop for exactly one cycle, latch res_data into a 32-bit holding register, clear the byte index to 0 and enter SEND.
REQ-015 SHALL assert tx_valid on the cycle after the pop (one-cycle latency) and hold tx_valid, tx_byte and tx_last stable until tx_valid and tx_ready are both high.
REQ-016 SHALL select tx_byte from the holding register by the 2-bit byte index, in the order set by MSB_FIRST.
REQ-017 SHALL increment the byte index on each handshake and assert tx_last only when the index is 3.
REQ-018 SHALL, on the index-3 handshake with res_empty low, pop and latch the next hash in that same cycle and stay in SEND with index 0, giving no bubble between hashes.
REQ-019 SHALL, on the index-3 handshake with res_empty high, deassert tx_valid on the next cycle and return to IDLE.
REQ-020 SHALL never assert res_pop while res_empty is high.
REQ-021 SHALL never assert res_pop while a latched hash still has unsent bytes.
REQ-022 SHALL ignore tx_ready in IDLE when the underflow feature is compiled out.
REQ-023 SHALL register all outputs except res_pop; res_pop may be a combinational strobe derived from registered state.

Reset
REQ-024 SHALL, while reset is high, immediately drive state IDLE, byte index 0, res_pop 0, tx_valid 0, tx_byte 8'h00, tx_last 0, underflow 0 and holding register 0.
REQ-025 SHALL discard any partially sent hash on reset mid-SEND without popping again; the remaining bytes of that hash are lost.

Configuration
REQ-026 SHALL, when HASH_READOUT_UNDERFLOW_EN is defined, go from IDLE to FILL when tx_ready is high and res_empty is high, then present IDLE_BYTE with tx_valid=1, tx_last=1.
REQ-027 SHALL, in FILL, set underflow, return to IDLE on the handshake, and clear underflow only on reset.
REQ-028 SHALL, when HASH_READOUT_UNDERFLOW_EN is undefined, omit the FILL state and tie underflow to 0.

Structure
REQ-029 SHALL take hash_t (32-bit), HASH_BYTES=4 and the state enum from the shared package hasher_pkg.
REQ-030 SHALL be a single module with no sub-module; byte selection is an inline mux.

Verification
REQ-031 SHALL cover: FIFO holds 32'h811C9DC5, tx_ready=1, MSB_FIRST=1 -> bytes 8'h81,8'h1C,8'h9D,8'hC5, tx_last on 8'hC5, exactly one res_pop.
REQ-032 SHALL cover: same word with MSB_FIRST=0 -> bytes 8'hC5,8'h9D,8'h1C,8'h81.
REQ-033 SHALL cover: two hashes 32'hE40C292C and 32'h050C5D7E queued, tx_ready=1 -> 8 consecutive valid cycles, second res_pop in the same cycle as the first tx_last handshake.
REQ-034 SHALL cover: tx_ready toggled 1,0,0,1 during SEND -> tx_byte held stable while stalled, no byte lost or duplicated.
REQ-035 SHALL cover: reset asserted after the second byte of 32'h811C9DC5 -> outputs zero at once, IDLE after release, next hash starts at byte 0.
REQ-036 SHALL cover, with HASH_READOUT_UNDERFLOW_EN defined: empty FIFO, tx_ready=1 -> one 8'hFF byte with tx_last=1, underflow=1 held until reset, res_pop never asserted.
